// File: rtl/bcd_modn_counter.sv
// Multi-digit packed-BCD modulo counter (0..MOD-1), up/down, with synchronous
// clear, checked preset load and a combinational terminal count for cascading.
module bcd_modn_counter #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned MOD    = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt_bcd,
  output logic                  tc,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // When the modulus equals 10^DIGITS it does not fit in W BCD bits; then
  // every well-formed BCD preset is in range and the magnitude test is skipped.
  localparam logic [W-1:0] MAX_BCD  = to_bcd(MOD - 1);
  localparam logic [W-1:0] MOD_BCD  = to_bcd(MOD);
  localparam bit           MOD_FULL = (MOD >= 10 ** DIGITS);

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic [W-1:0] next_cnt;
  logic         next_err;
  logic         at_max;
  logic         at_zero;
  logic         nibbles_ok;
  logic         load_ok;

  assign at_max  = (cnt_bcd == MAX_BCD);
  assign at_zero = (cnt_bcd == '0);

  // Per-digit BCD increment (carry on 9) and decrement (borrow on 0).
  always_comb begin : p_arith
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    inc_val = '0;
    dec_val = '0;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = cnt_bcd[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = d + 4'd1;
          carry = 1'b0;
        end
      end else begin
        inc_val[4*i +: 4] = d;
      end
      if (borrow) begin
        if (d == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = d - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        dec_val[4*i +: 4] = d;
      end
    end
  end

  // Preset validity: all nibbles decimal and the whole value below MOD.
  // Packed BCD of valid digits orders the same as the decimal value.
  always_comb begin
    nibbles_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) nibbles_ok = 1'b0;
    end
    load_ok = nibbles_ok & (MOD_FULL | (load_val < MOD_BCD));
  end

  // Next-state selection with priority clr > load > en > hold.
  always_comb begin
    next_cnt = cnt_bcd;
    next_err = 1'b0;
    if (clr) begin
      next_cnt = '0;
    end else if (load) begin
      if (load_ok) next_cnt = load_val;
      else         next_err = 1'b1;
    end else if (en) begin
      if (up) next_cnt = at_max  ? '0      : inc_val;
      else    next_cnt = at_zero ? MAX_BCD : dec_val;
    end
  end

  assign tc = en & ~clr & ~load & (up ? at_max : at_zero);

  // Count and load-error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_bcd  <= '0;
      load_err <= 1'b0;
    end else begin
      cnt_bcd  <= next_cnt;
      load_err <= next_err;
    end
  end

endmodule

// File: tb/tb_bcd_modn_counter.sv
// Directed self-checking bench for bcd_modn_counter: mod-60 unit, a
// 60/60/24 cascade and a 3-digit mod-1000 unit share one clock.
module tb_bcd_modn_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Main mod-60 unit
  logic       en, up, clr, load;
  logic [7:0] load_val, cnt;
  logic       tc, load_err;

  bcd_modn_counter #(.DIGITS(2), .MOD(60)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .cnt_bcd(cnt), .tc(tc), .load_err(load_err)
  );

  // Cascade sec -> min -> hr
  logic       c_en, c_load;
  logic [7:0] lv_s, lv_m, lv_h, cnt_s, cnt_m, cnt_h;
  logic       tc_s, tc_m, tc_h, err_s, err_m, err_h;

  bcd_modn_counter #(.DIGITS(2), .MOD(60)) u_sec (
    .clk(clk), .rst_n(rst_n), .en(c_en), .up(1'b1), .clr(1'b0), .load(c_load),
    .load_val(lv_s), .cnt_bcd(cnt_s), .tc(tc_s), .load_err(err_s)
  );
  bcd_modn_counter #(.DIGITS(2), .MOD(60)) u_min (
    .clk(clk), .rst_n(rst_n), .en(tc_s), .up(1'b1), .clr(1'b0), .load(c_load),
    .load_val(lv_m), .cnt_bcd(cnt_m), .tc(tc_m), .load_err(err_m)
  );
  bcd_modn_counter #(.DIGITS(2), .MOD(24)) u_hr (
    .clk(clk), .rst_n(rst_n), .en(tc_m), .up(1'b1), .clr(1'b0), .load(c_load),
    .load_val(lv_h), .cnt_bcd(cnt_h), .tc(tc_h), .load_err(err_h)
  );

  // Wide mod-1000 unit
  logic        w_en, w_up, w_clr, w_load;
  logic [11:0] w_lv, w_cnt;
  logic        w_tc, w_err;

  bcd_modn_counter #(.DIGITS(3), .MOD(1000)) u_wide (
    .clk(clk), .rst_n(rst_n), .en(w_en), .up(w_up), .clr(w_clr), .load(w_load),
    .load_val(w_lv), .cnt_bcd(w_cnt), .tc(w_tc), .load_err(w_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en = 0; up = 1; clr = 0; load = 0; load_val = '0;
    c_en = 0; c_load = 0; lv_s = '0; lv_m = '0; lv_h = '0;
    w_en = 0; w_up = 1; w_clr = 0; w_load = 0; w_lv = '0;
    #1;
    n_checks++;
    if (cnt !== 8'h00) begin n_bad++; $display("FAIL reset_cnt got=%h exp=00", cnt); end
    n_checks++;
    if (load_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", load_err); end
    n_checks++;
    if (w_cnt !== 12'h000) begin n_bad++; $display("FAIL reset_wide got=%h exp=000", w_cnt); end
    tick; tick;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_count_up;
    logic [7:0] exp_v;
    int v;
    en = 1; up = 1;
    for (int i = 0; i <= 60; i++) begin
      v = i % 60;
      exp_v = {4'(v / 10), 4'(v % 10)};
      #1;
      n_checks++;
      if (cnt !== exp_v) begin n_bad++; $display("FAIL up_cnt step=%0d got=%h exp=%h", i, cnt, exp_v); end
      n_checks++;
      if (tc !== (v == 59)) begin n_bad++; $display("FAIL up_tc step=%0d got=%b exp=%b", i, tc, (v == 59)); end
      tick;
    end
    en = 0;
  endtask

  task automatic test_count_down;
    clr = 1; tick; clr = 0;
    n_checks++;
    if (cnt !== 8'h00) begin n_bad++; $display("FAIL clr_cnt got=%h exp=00", cnt); end
    en = 1; up = 0; #1;
    n_checks++;
    if (tc !== 1'b1) begin n_bad++; $display("FAIL down_tc0 got=%b exp=1", tc); end
    tick;
    n_checks++;
    if (cnt !== 8'h59) begin n_bad++; $display("FAIL down_wrap got=%h exp=59", cnt); end
    n_checks++;
    if (tc !== 1'b0) begin n_bad++; $display("FAIL down_tc59 got=%b exp=0", tc); end
    tick;
    n_checks++;
    if (cnt !== 8'h58) begin n_bad++; $display("FAIL down_58 got=%h exp=58", cnt); end
    en = 0; load = 1; load_val = 8'h50; tick; load = 0;
    en = 1; tick; en = 0;
    n_checks++;
    if (cnt !== 8'h49) begin n_bad++; $display("FAIL down_borrow got=%h exp=49", cnt); end
    up = 1;
  endtask

  task automatic test_load;
    load = 1; load_val = 8'h45; tick;
    n_checks++;
    if (cnt !== 8'h45) begin n_bad++; $display("FAIL load45 got=%h exp=45", cnt); end
    n_checks++;
    if (load_err !== 1'b0) begin n_bad++; $display("FAIL load45_err got=%b exp=0", load_err); end
    load_val = 8'h60; en = 1; tick;
    n_checks++;
    if (cnt !== 8'h45) begin n_bad++; $display("FAIL load60_hold got=%h exp=45", cnt); end
    n_checks++;
    if (load_err !== 1'b1) begin n_bad++; $display("FAIL load60_err got=%b exp=1", load_err); end
    load_val = 8'h3A; en = 0; tick;
    n_checks++;
    if (load_err !== 1'b1) begin n_bad++; $display("FAIL load3A_err got=%b exp=1", load_err); end
    n_checks++;
    if (cnt !== 8'h45) begin n_bad++; $display("FAIL load3A_hold got=%h exp=45", cnt); end
    load = 0; tick;
    n_checks++;
    if (load_err !== 1'b0) begin n_bad++; $display("FAIL err_drop got=%b exp=0", load_err); end
    load = 1; load_val = 8'h59; tick;
    n_checks++;
    if (cnt !== 8'h59) begin n_bad++; $display("FAIL load59 got=%h exp=59", cnt); end
    load_val = 8'h45; clr = 1; tick;
    n_checks++;
    if (cnt !== 8'h00) begin n_bad++; $display("FAIL loadclr_cnt got=%h exp=00", cnt); end
    n_checks++;
    if (load_err !== 1'b0) begin n_bad++; $display("FAIL loadclr_err got=%b exp=0", load_err); end
    load = 0; clr = 0;
  endtask

  task automatic test_priority;
    load = 1; load_val = 8'h59; tick;
    en = 1; clr = 1; up = 1; load_val = 8'h45; #1;
    n_checks++;
    if (tc !== 1'b0) begin n_bad++; $display("FAIL prio_tc got=%b exp=0", tc); end
    tick;
    n_checks++;
    if (cnt !== 8'h00) begin n_bad++; $display("FAIL prio_cnt got=%h exp=00", cnt); end
    clr = 0; en = 0; load_val = 8'h59; tick;
    load = 0; #1;
    n_checks++;
    if (tc !== 1'b0) begin n_bad++; $display("FAIL mask_tc got=%b exp=0", tc); end
    tick;
    n_checks++;
    if (cnt !== 8'h59) begin n_bad++; $display("FAIL mask_hold got=%h exp=59", cnt); end
    en = 1; #1;
    n_checks++;
    if (tc !== 1'b1) begin n_bad++; $display("FAIL tc59 got=%b exp=1", tc); end
    tick; en = 0;
    n_checks++;
    if (cnt !== 8'h00) begin n_bad++; $display("FAIL wrap59 got=%h exp=00", cnt); end
  endtask

  task automatic test_cascade;
    c_load = 1; lv_s = 8'h12; lv_m = 8'h34; lv_h = 8'h24; tick;
    n_checks++;
    if ({err_h, err_m, err_s} !== 3'b100) begin n_bad++; $display("FAIL casc_err got=%b exp=100", {err_h, err_m, err_s}); end
    n_checks++;
    if ({cnt_h, cnt_m, cnt_s} !== 24'h003412) begin n_bad++; $display("FAIL casc_part got=%h exp=003412", {cnt_h, cnt_m, cnt_s}); end
    lv_s = 8'h59; lv_m = 8'h59; lv_h = 8'h23; tick;
    c_load = 0;
    n_checks++;
    if ({cnt_h, cnt_m, cnt_s} !== 24'h235959) begin n_bad++; $display("FAIL casc_preset got=%h exp=235959", {cnt_h, cnt_m, cnt_s}); end
    c_en = 1; #1;
    n_checks++;
    if ({tc_h, tc_m, tc_s} !== 3'b111) begin n_bad++; $display("FAIL casc_tc got=%b exp=111", {tc_h, tc_m, tc_s}); end
    tick; c_en = 0;
    n_checks++;
    if ({cnt_h, cnt_m, cnt_s} !== 24'h000000) begin n_bad++; $display("FAIL casc_wrap got=%h exp=000000", {cnt_h, cnt_m, cnt_s}); end
    c_en = 1; tick; c_en = 0;
    n_checks++;
    if ({cnt_h, cnt_m, cnt_s} !== 24'h000001) begin n_bad++; $display("FAIL casc_step got=%h exp=000001", {cnt_h, cnt_m, cnt_s}); end
  endtask

  task automatic test_async_reset;
    load = 1; load_val = 8'h37; tick; load = 0;
    n_checks++;
    if (cnt !== 8'h37) begin n_bad++; $display("FAIL ar_pre got=%h exp=37", cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (cnt !== 8'h00) begin n_bad++; $display("FAIL ar_async got=%h exp=00", cnt); end
    tick;
    rst_n = 1'b1; en = 1; up = 1;
    tick; en = 0;
    n_checks++;
    if (cnt !== 8'h01) begin n_bad++; $display("FAIL ar_resume got=%h exp=01", cnt); end
  endtask

  task automatic test_wide;
    w_load = 1; w_lv = 12'h999; tick; w_load = 0;
    w_en = 1; w_up = 1; #1;
    n_checks++;
    if (w_tc !== 1'b1) begin n_bad++; $display("FAIL w_tc999 got=%b exp=1", w_tc); end
    tick;
    n_checks++;
    if (w_cnt !== 12'h000) begin n_bad++; $display("FAIL w_wrap got=%h exp=000", w_cnt); end
    w_up = 0; #1;
    n_checks++;
    if (w_tc !== 1'b1) begin n_bad++; $display("FAIL w_tc000 got=%b exp=1", w_tc); end
    tick; w_en = 0;
    n_checks++;
    if (w_cnt !== 12'h999) begin n_bad++; $display("FAIL w_down got=%h exp=999", w_cnt); end
    w_load = 1; w_lv = 12'h099; tick; w_load = 0;
    w_en = 1; w_up = 1; tick; w_en = 0;
    n_checks++;
    if (w_cnt !== 12'h100) begin n_bad++; $display("FAIL w_carry got=%h exp=100", w_cnt); end
    w_load = 1; w_lv = 12'h9A9; tick; w_load = 0;
    n_checks++;
    if (w_err !== 1'b1 || w_cnt !== 12'h100) begin n_bad++; $display("FAIL w_badload got=%b/%h exp=1/100", w_err, w_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_count_up;
    test_count_down;
    test_load;
    test_priority;
    test_cascade;
    test_async_reset;
    test_wide;
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
